alu_sequencer: RTL and testbench

- Multi-cycle control sequencer that drives the ALU: accepts one 32-bit instruction per handshake, decodes it, and issues register addresses, operand selects and the 3-bit ALU operation code.
- Consumes the ALU ZERO flag to resolve jump and beq.
- Owns the PC and the register-file write enable.
- Sits between the instruction memory/fetch interface and the datapath (register file + ALU).

---
 rtl/alu_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle IDLE/DECODE/EXEC/WB controller issuing register addresses and ALU controls.
// Optional bne (opcode 0x0B) is compiled in when ALU_SEQ_BNE_EN is defined; otherwise 0x0B is illegal.
module alu_sequencer #(
    parameter int              PC_W     = 32,
    parameter int              EXEC_CYC = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [31:0]     INSTR,
    input  logic            INSTR_VALID,
    output logic            INSTR_READY,
    input  logic            ZERO,
    output logic [2:0]      READREG1,
    output logic [2:0]      READREG2,
    output logic [2:0]      WRITEREG,
    output logic            WRITEENABLE,
    output logic [2:0]      ALUOP,
    output logic            IMM_SEL,
    output logic            NEG_SEL,
    output logic [7:0]      IMMEDIATE,
    output logic [PC_W-1:0] PC,
    output logic            ILLEGAL,
    output logic [1:0]      STATE_DBG
);

    // Handshake: INSTR is taken on a rising edge where INSTR_VALID && INSTR_READY.
    // INSTR_READY is high only in IDLE, so the source holds VALID/INSTR until that edge.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] aluop;
        logic       imm_sel;
        logic       neg_sel;
        logic       wr;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] op);
        dec_t d;
        d = '0;
        case (op)
            8'h00: begin d.aluop = 3'b000; d.imm_sel = 1'b1; d.wr = 1'b1; end
            8'h01: begin d.aluop = 3'b000; d.wr = 1'b1; end
            8'h02: begin d.aluop = 3'b001; d.wr = 1'b1; end
            8'h03: begin d.aluop = 3'b001; d.neg_sel = 1'b1; d.wr = 1'b1; end
            8'h04: begin d.aluop = 3'b010; d.wr = 1'b1; end
            8'h05: begin d.aluop = 3'b011; d.wr = 1'b1; end
            8'h06: begin d.aluop = 3'b000; d.jump = 1'b1; end
            8'h07: begin d.aluop = 3'b001; d.neg_sel = 1'b1; d.beq = 1'b1; end
            8'h08: begin d.aluop = 3'b100; d.wr = 1'b1; end
            8'h09: begin d.aluop = 3'b101; d.imm_sel = 1'b1; d.wr = 1'b1; end
            8'h0A: begin d.aluop = 3'b110; d.imm_sel = 1'b1; d.wr = 1'b1; end
`ifdef ALU_SEQ_BNE_EN
            8'h0B: begin d.aluop = 3'b001; d.neg_sel = 1'b1; d.bne = 1'b1; end
`else
            8'h0B: d.illegal = 1'b1;
`endif
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    dec_t            dec_q, dec_d;
    logic [7:0]      off_q, off_d;
    logic            zero_q, zero_d;
    logic            ready_q, ready_d;
    logic [2:0]      rr1_q, rr1_d;
    logic [2:0]      rr2_q, rr2_d;
    logic [2:0]      wreg_q, wreg_d;
    logic [7:0]      imm_q, imm_d;
    logic            we_q, we_d;
    logic            ill_q, ill_d;
    logic [PC_W-1:0] pc_q, pc_d;

    dec_t            dec_in;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_tgt;
    logic            taken;
    logic            unused_src1_hi;

    assign dec_in         = decode(INSTR[31:24]);
    assign unused_src1_hi = ^INSTR[15:11];

    // Branch target is relative to the following instruction; wrap is silent.
    assign off_ext = {{(PC_W-8){off_q[7]}}, off_q};
    assign pc_seq  = pc_q + PC_W'(4);
    assign pc_tgt  = pc_seq + (off_ext << 2);
    assign taken   = dec_q.jump | (dec_q.beq & zero_q) | (dec_q.bne & ~zero_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        off_d   = off_q;
        zero_d  = zero_q;
        ready_d = ready_q;
        rr1_d   = rr1_q;
        rr2_d   = rr2_q;
        wreg_d  = wreg_q;
        imm_d   = imm_q;
        we_d    = 1'b0;
        ill_d   = 1'b0;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (INSTR_VALID && ready_q) begin
                    dec_d   = dec_in;
                    off_d   = INSTR[23:16];
                    rr1_d   = INSTR[10:8];
                    rr2_d   = INSTR[2:0];
                    wreg_d  = INSTR[18:16];
                    imm_d   = INSTR[7:0];
                    ready_d = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d = '0;
                if (dec_q.illegal) begin
                    ill_d   = 1'b1;
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // ZERO is only meaningful once the ALU has settled on the last cycle.
                if (cnt_q == 4'(EXEC_CYC - 1)) begin
                    zero_d  = ZERO;
                    we_d    = dec_q.wr;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WB: begin
                pc_d    = taken ? pc_tgt : pc_seq;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dec_q   <= '0;
            off_q   <= '0;
            zero_q  <= 1'b0;
            ready_q <= 1'b1;
            rr1_q   <= '0;
            rr2_q   <= '0;
            wreg_q  <= '0;
            imm_q   <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            off_q   <= off_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            rr1_q   <= rr1_d;
            rr2_q   <= rr2_d;
            wreg_q  <= wreg_d;
            imm_q   <= imm_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
            pc_q    <= pc_d;
        end
    end

    assign INSTR_READY = ready_q;
    assign READREG1    = rr1_q;
    assign READREG2    = rr2_q;
    assign WRITEREG    = wreg_q;
    assign WRITEENABLE = we_q;
    assign ALUOP       = dec_q.aluop;
    assign IMM_SEL     = dec_q.imm_sel;
    assign NEG_SEL     = dec_q.neg_sel;
    assign IMMEDIATE   = imm_q;
    assign PC          = pc_q;
    assign ILLEGAL     = ill_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, multi-cycle corner sequences and
// random instructions checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int          PC_W   = 32;
    localparam int          E      = 2;
    localparam logic [31:0] RST_PC = 32'h0;
`ifdef ALU_SEQ_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic [31:0]     INSTR = '0;
    logic            INSTR_VALID = 1'b0;
    logic            INSTR_READY;
    logic            ZERO = 1'b0;
    logic [2:0]      READREG1, READREG2, WRITEREG, ALUOP;
    logic            WRITEENABLE, IMM_SEL, NEG_SEL, ILLEGAL;
    logic [7:0]      IMMEDIATE;
    logic [PC_W-1:0] PC;
    logic [1:0]      STATE_DBG;

    alu_sequencer #(.PC_W(PC_W), .EXEC_CYC(E), .RESET_PC(RST_PC)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .ZERO(ZERO), .READREG1(READREG1),
        .READREG2(READREG2), .WRITEREG(WRITEREG), .WRITEENABLE(WRITEENABLE),
        .ALUOP(ALUOP), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE),
        .PC(PC), .ILLEGAL(ILLEGAL), .STATE_DBG(STATE_DBG)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

    typedef struct packed {
        logic [2:0] aluop;
        logic       imm;
        logic       neg;
        logic       wr;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] zseq;
        exp_t        e;
        logic [31:0] pc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_pc;
    vec_t        vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] aluop, input logic imm, input logic neg,
                                input logic wr, input logic ill);
        exp_t e;
        e.aluop = aluop; e.imm = imm; e.neg = neg; e.wr = wr; e.ill = ill;
        return e;
    endfunction

    // reference model: opcode table and PC arithmetic
    function automatic exp_t model_dec(input logic [7:0] op);
        case (op)
            8'h00: return mk(3'd0, 1, 0, 1, 0);
            8'h01: return mk(3'd0, 0, 0, 1, 0);
            8'h02: return mk(3'd1, 0, 0, 1, 0);
            8'h03: return mk(3'd1, 0, 1, 1, 0);
            8'h04: return mk(3'd2, 0, 0, 1, 0);
            8'h05: return mk(3'd3, 0, 0, 1, 0);
            8'h06: return mk(3'd0, 0, 0, 0, 0);
            8'h07: return mk(3'd1, 0, 1, 0, 0);
            8'h08: return mk(3'd4, 0, 0, 1, 0);
            8'h09: return mk(3'd5, 1, 0, 1, 0);
            8'h0A: return mk(3'd6, 1, 0, 1, 0);
            8'h0B: return BNE_EN ? mk(3'd1, 0, 1, 0, 0) : mk(3'd0, 0, 0, 0, 1);
            default: return mk(3'd0, 0, 0, 0, 1);
        endcase
    endfunction

    function automatic logic [31:0] model_pc(input logic [7:0] op, input logic [31:0] pc,
                                             input logic [7:0] off, input logic z);
        bit taken;
        int soff;
        taken = (op == 8'h06) || (op == 8'h07 && z) || (BNE_EN && op == 8'h0B && !z);
        soff  = int'($signed(off));
        return taken ? pc + 32'd4 + 32'(soff * 4) : pc + 32'd4;
    endfunction

    task automatic add_vec(input logic [31:0] instr, input logic [31:0] zseq,
                           input exp_t e, input logic [31:0] pc);
        vec_t v;
        v.instr = instr; v.zseq = zseq; v.e = e; v.pc = pc;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0; INSTR_VALID = 1'b0; ZERO = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        ref_pc = RST_PC;
    endtask

    // driver + per-instruction checker; cycle 1 is the accepting IDLE cycle
    task automatic run_instr(input string name, input logic [31:0] ins, input logic [31:0] zseq,
                             input exp_t e, input bit chained, input bit hold_next,
                             input logic [31:0] next_ins);
        int waitc, cyc, we_cnt, we_cyc, ill_cnt, ill_cyc, unstable, done_cyc;
        logic [31:0] exp_pc;
        exp_pc = exp_q.pop_front();
        if (!chained) begin
            @(negedge CLK);
            waitc = 0;
            while (INSTR_READY !== 1'b1 && waitc < 50) begin
                @(negedge CLK);
                waitc++;
            end
        end
        check({name, ".ready_idle"}, INSTR_READY, 1);
        if (INSTR_READY !== 1'b1) return;
        INSTR = ins; INSTR_VALID = 1'b1; ZERO = 1'b0;
        @(negedge CLK);
        check({name, ".ready_busy"}, INSTR_READY, 0);
        check({name, ".readreg1"}, READREG1, ins[10:8]);
        check({name, ".readreg2"}, READREG2, ins[2:0]);
        check({name, ".writereg"}, WRITEREG, ins[18:16]);
        check({name, ".immediate"}, IMMEDIATE, ins[7:0]);
        check({name, ".aluop"}, ALUOP, e.aluop);
        check({name, ".imm_sel"}, IMM_SEL, e.imm);
        check({name, ".neg_sel"}, NEG_SEL, e.neg);
        if (hold_next) INSTR = next_ins;
        else begin
            INSTR_VALID = 1'b0;
            INSTR = $urandom;
        end
        cyc = 2; we_cnt = 0; we_cyc = 0; ill_cnt = 0; ill_cyc = 0; unstable = 0; done_cyc = 0;
        while (cyc < 40) begin
            if (WRITEENABLE === 1'b1) begin we_cnt++; we_cyc = cyc; end
            if (ILLEGAL === 1'b1) begin ill_cnt++; ill_cyc = cyc; end
            if (ALUOP !== e.aluop || IMM_SEL !== e.imm || NEG_SEL !== e.neg ||
                READREG1 !== ins[10:8] || READREG2 !== ins[2:0] ||
                WRITEREG !== ins[18:16] || IMMEDIATE !== ins[7:0]) unstable++;
            if (INSTR_READY === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            ZERO = (cyc < 32) ? zseq[cyc] : 1'b0;
            @(negedge CLK);
            cyc++;
        end
        ZERO = 1'b0;
        check({name, ".latency"}, done_cyc, e.ill ? 4 : 4 + E);
        check({name, ".we_pulses"}, we_cnt, e.wr);
        check({name, ".we_cycle"}, we_cyc, e.wr ? 3 + E : 0);
        check({name, ".illegal_pulses"}, ill_cnt, e.ill);
        check({name, ".illegal_cycle"}, ill_cyc, e.ill ? 3 : 0);
        check({name, ".outputs_stable"}, unstable, 0);
        check({name, ".pc"}, PC, exp_pc);
    endtask

    task automatic run_model(input string name, input logic [31:0] ins, input logic [31:0] zseq);
        logic [31:0] nxt;
        nxt = model_pc(ins[31:24], ref_pc, ins[23:16], zseq[2 + E]);
        exp_q.push_back(nxt);
        ref_pc = nxt;
        run_instr(name, ins, zseq, model_dec(ins[31:24]), 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int we_seen;
        logic [31:0] ins, zs;
        logic [7:0]  op;

        // reset state
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst.ready", INSTR_READY, 1);
        check("rst.pc", PC, RST_PC);
        check("rst.we", WRITEENABLE, 0);
        check("rst.illegal", ILLEGAL, 0);
        check("rst.aluop", ALUOP, 0);
        check("rst.sels", {IMM_SEL, NEG_SEL}, 0);
        check("rst.regs", {READREG1, READREG2, WRITEREG}, 0);
        check("rst.imm", IMMEDIATE, 0);
        check("rst.state", STATE_DBG, 0);
        RESET = 1'b1;
        ref_pc = RST_PC;

        // directed table, PC chained from 0
        add_vec(32'h00020005, 32'h0,  mk(3'd0, 1, 0, 1, 0), 32'h4);
        add_vec(32'h03010203, 32'h0,  mk(3'd1, 0, 1, 1, 0), 32'h8);
        add_vec(32'h06010000, 32'h0,  mk(3'd0, 0, 0, 0, 0), 32'h10);
        add_vec(32'h07FE0000, 32'h10, mk(3'd1, 0, 1, 0, 0), 32'h0C);
        add_vec(32'h00030007, 32'h0,  mk(3'd0, 1, 0, 1, 0), 32'h10);
        add_vec(32'h07FE0000, 32'h08, mk(3'd1, 0, 1, 0, 0), 32'h14);
        add_vec(32'hFF000000, 32'h0,  mk(3'd0, 0, 0, 0, 1), 32'h18);
        add_vec(32'h04050607, 32'h0,  mk(3'd2, 0, 0, 1, 0), 32'h1C);
        add_vec(32'h05070102, 32'h0,  mk(3'd3, 0, 0, 1, 0), 32'h20);
        add_vec(32'h08010203, 32'h0,  mk(3'd4, 0, 0, 1, 0), 32'h24);
        add_vec(32'h09020003, 32'h0,  mk(3'd5, 1, 0, 1, 0), 32'h28);
        add_vec(32'h0A030001, 32'h0,  mk(3'd6, 1, 0, 1, 0), 32'h2C);
        add_vec(32'h01040500, 32'h0,  mk(3'd0, 0, 0, 1, 0), 32'h30);
        add_vec(32'h02010203, 32'h0,  mk(3'd1, 0, 0, 1, 0), 32'h34);
        add_vec(32'h07800000, 32'h10, mk(3'd1, 0, 1, 0, 0), 32'hFFFFFE38);
        add_vec(32'h07FF0000, 32'h10, mk(3'd1, 0, 1, 0, 0), 32'hFFFFFE38);
        add_vec(32'h067F0000, 32'h0,  mk(3'd0, 0, 0, 0, 0), 32'h38);
`ifdef ALU_SEQ_BNE_EN
        add_vec(32'h0B010000, 32'h0,  mk(3'd1, 0, 1, 0, 0), 32'h40);
`else
        add_vec(32'h0B010000, 32'h0,  mk(3'd0, 0, 0, 0, 1), 32'h3C);
`endif
        for (int i = 0; i < vq.size(); i++) begin
            exp_q.push_back(vq[i].pc);
            run_instr($sformatf("vec%0d", i), vq[i].instr, vq[i].zseq, vq[i].e, 1'b0, 1'b0, 32'h0);
            ref_pc = vq[i].pc;
        end

        // VALID held during DECODE/EXEC/WB: next instruction waits for IDLE
        exp_q.push_back(ref_pc + 32'd4);
        exp_q.push_back(ref_pc + 32'd8);
        run_instr("hold.a", 32'h02010203, 32'h0, mk(3'd1, 0, 0, 1, 0), 1'b0, 1'b1, 32'h00060009);
        run_instr("hold.b", 32'h00060009, 32'h0, mk(3'd0, 1, 0, 1, 0), 1'b1, 1'b0, 32'h0);
        ref_pc = ref_pc + 32'd8;

        // random instructions against the model
        for (int i = 0; i < 40; i++) begin
            op  = 8'($urandom_range(0, 12));
            if (op == 8'd12) op = 8'($urandom_range(12, 255));
            ins = {op, 24'($urandom)};
            zs  = $urandom;
            run_model($sformatf("rnd%0d", i), ins, zs);
        end

        // reset asserted in EXEC of an add aborts it
        @(negedge CLK);
        INSTR = 32'h02010203; INSTR_VALID = 1'b1;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("abort.pc", PC, RST_PC);
        check("abort.ready", INSTR_READY, 1);
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (WRITEENABLE === 1'b1) we_seen++;
        end
        RESET = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (WRITEENABLE === 1'b1) we_seen++;
        end
        check("abort.we", we_seen, 0);
        check("abort.ready_release", INSTR_READY, 1);
        check("abort.pc_release", PC, RST_PC);
        ref_pc = RST_PC;

        run_model("j7f_from0", 32'h067F0000, 32'h0);
        check("j7f_from0.pc_abs", PC, 32'h200);

`ifdef ALU_SEQ_BNE_EN
        do_reset();
        run_model("bne_taken", 32'h0B010000, 32'h0);
        check("bne_taken.pc_abs", PC, 32'h8);
        run_model("bne_not_taken", 32'h0B010000, 32'h10);
        check("bne_not_taken.pc_abs", PC, 32'hC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
